// File: rtl/z2_ram_pkg.sv
// Shared state encoding, default timing and helpers for the Zorro II FastRAM DRAM sequencer.
package z2_ram_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRow,
      StCol,
      StPre,
      StRcas,
      StRras
   } z2_state_t;

   // Bus-phase clock period (7.09 MHz) in picoseconds.
   localparam int unsigned CLK_PERIOD_PS    = 141044;

   localparam int unsigned DEF_BANKS        = 4;
   localparam int unsigned DEF_AW           = 10;
   localparam int unsigned DEF_REF_INTERVAL = 108;
   localparam int unsigned DEF_REF_MAX      = 4;
   localparam int unsigned DEF_PRE_CYC      = 1;
   localparam int unsigned DEF_REF_RAS_CYC  = 2;

   // A single-bank card still carries a 1-bit BANK port.
   function automatic int unsigned bank_w(input int unsigned banks);
      return (banks > 1) ? $clog2(banks) : 1;
   endfunction

endpackage

// File: rtl/z2_refresh_timer.sv
// Refresh interval counter and saturating backlog of pending CBR refreshes.
module z2_refresh_timer import z2_ram_pkg::*; #(
   parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL,
   parameter int unsigned REF_MAX      = DEF_REF_MAX
) (
   input  logic                               CLK,
   input  logic                               RESETn,
   input  logic                               ref_done,
   output logic [$clog2(REF_MAX + 1)-1:0]     REF_PEND
);

   localparam int unsigned CW = $clog2(REF_INTERVAL);
   localparam int unsigned PW = $clog2(REF_MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [PW-1:0] pend_q;
   logic          tick;

   assign tick     = (cnt_q == CW'(REF_INTERVAL - 1));
   assign REF_PEND = pend_q;

   // A tick landing on a completion cancels out; otherwise saturate at both ends.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q  <= '0;
         pend_q <= '0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
         if (tick && !ref_done) begin
            if (pend_q != PW'(REF_MAX)) pend_q <= pend_q + 1'b1;
         end else if (ref_done && !tick) begin
            if (pend_q != '0) pend_q <= pend_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/z2_dram_ctrl.sv
// FPM/EDO DRAM sequencer for Zorro II FastRAM: CPU accesses arbitrated against CBR refresh.
module z2_dram_ctrl import z2_ram_pkg::*; #(
   parameter int unsigned BANKS        = DEF_BANKS,
   parameter int unsigned AW           = DEF_AW,
   parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL,
   parameter int unsigned REF_MAX      = DEF_REF_MAX,
   parameter int unsigned PRE_CYC      = DEF_PRE_CYC,
   parameter int unsigned REF_RAS_CYC  = DEF_REF_RAS_CYC
) (
   input  logic                           CLK,
   input  logic                           RESETn,
   input  logic                           ASn,
   input  logic                           UDSn,
   input  logic                           LDSn,
   input  logic                           RWn,
   input  logic                           SEL,
   input  logic [bank_w(BANKS)-1:0]       BANK,
   input  logic [AW-1:0]                  ROW,
   input  logic [AW-1:0]                  COL,
   output logic [BANKS-1:0]               RASn,
   output logic                           UCASn,
   output logic                           LCASn,
   output logic [AW-1:0]                  MADDR,
   output logic                           MEMWn,
   output logic                           DTACKn,
   output logic [$clog2(REF_MAX + 1)-1:0] REF_PEND
);

   localparam int unsigned BW   = bank_w(BANKS);
   localparam int unsigned PW   = $clog2(REF_MAX + 1);
   localparam int unsigned TMAX = (PRE_CYC > REF_RAS_CYC) ? PRE_CYC : REF_RAS_CYC;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   z2_state_t        state_q;
   logic [TW-1:0]    cnt_q;
   logic [BANKS-1:0] bank_ras_n;
   logic             acc_go;
   logic             ref_go;
   logic             ref_done;

   z2_refresh_timer #(
      .REF_INTERVAL (REF_INTERVAL),
      .REF_MAX      (REF_MAX)
   ) u_refresh_timer (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .ref_done (ref_done),
      .REF_PEND (REF_PEND)
   );

   always_comb begin
      bank_ras_n = '1;
      for (int i = 0; i < BANKS; i++) begin
         if (BANKS == 1 || BANK == BW'(i)) bank_ras_n[i] = 1'b0;
      end
   end

   // A full backlog forces refresh ahead of a pending access.
   assign acc_go   = !ASn && SEL && (REF_PEND < PW'(REF_MAX));
   assign ref_go   = (REF_PEND != '0) && (ASn || !SEL || (REF_PEND == PW'(REF_MAX)));
   assign ref_done = (state_q == StRras) && (cnt_q == TW'(REF_RAS_CYC - 1));

   // Combinational so the acknowledge drops the moment the CPU ends the cycle.
   assign DTACKn   = !((state_q == StCol) && !ASn);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         RASn    <= '1;
         UCASn   <= 1'b1;
         LCASn   <= 1'b1;
         MADDR   <= '0;
         MEMWn   <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               MADDR <= ROW;
               if (acc_go) begin
                  state_q <= StRow;
                  RASn    <= bank_ras_n;
               end else if (ref_go) begin
                  state_q <= StRcas;
                  UCASn   <= 1'b0;
                  LCASn   <= 1'b0;
                  MEMWn   <= 1'b1;
               end
            end
            StRow: begin
               MADDR   <= COL;
               MEMWn   <= RWn;
               state_q <= StCol;
            end
            StCol: begin
               if (ASn) begin
                  state_q <= StPre;
                  cnt_q   <= '0;
                  RASn    <= '1;
                  UCASn   <= 1'b1;
                  LCASn   <= 1'b1;
                  MEMWn   <= 1'b1;
               end else begin
                  UCASn <= UDSn;
                  LCASn <= LDSn;
                  MEMWn <= RWn;
               end
            end
            StPre: begin
               if (cnt_q == TW'(PRE_CYC - 1)) state_q <= StIdle;
               else                            cnt_q   <= cnt_q + 1'b1;
            end
            StRcas: begin
               state_q <= StRras;
               cnt_q   <= '0;
               RASn    <= '0;
            end
            StRras: begin
               if (ref_done) begin
                  state_q <= StPre;
                  cnt_q   <= '0;
                  RASn    <= '1;
                  UCASn   <= 1'b1;
                  LCASn   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_z2_dram_ctrl.sv
// Scoreboard bench for z2_dram_ctrl: timeline-driven stimulus, event monitor pops expectations.
module tb_z2_dram_ctrl;

   localparam int K_ACC = 1;
   localparam int K_REF = 2;

   typedef struct {
      int         id;
      int         kind;
      int         cyc;
      int         len;
      logic [3:0] ras;
      logic [9:0] maddr;
      logic       memw;
      logic [1:0] cas;
   } sb_item_t;

   logic       CLK;
   logic       RESETn;
   logic       ASn;
   logic       UDSn;
   logic       LDSn;
   logic       RWn;
   logic       SEL;
   logic [1:0] BANK;
   logic [9:0] ROW;
   logic [9:0] COL;
   logic [3:0] RASn;
   logic       UCASn;
   logic       LCASn;
   logic [9:0] MADDR;
   logic       MEMWn;
   logic       DTACKn;
   logic [2:0] REF_PEND;

   int       n_cmp = 0;
   int       n_err = 0;
   int       cyc   = 0;
   logic     run   = 1'b0;
   sb_item_t sb_q[$];

   z2_dram_ctrl #(
      .BANKS        (4),
      .AW           (10),
      .REF_INTERVAL (108),
      .REF_MAX      (4),
      .PRE_CYC      (1),
      .REF_RAS_CYC  (2)
   ) dut (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .ASn      (ASn),
      .UDSn     (UDSn),
      .LDSn     (LDSn),
      .RWn      (RWn),
      .SEL      (SEL),
      .BANK     (BANK),
      .ROW      (ROW),
      .COL      (COL),
      .RASn     (RASn),
      .UCASn    (UCASn),
      .LCASn    (LCASn),
      .MADDR    (MADDR),
      .MEMWn    (MEMWn),
      .DTACKn   (DTACKn),
      .REF_PEND (REF_PEND)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edge number k = k-th rising edge after the first reset release.
   always @(posedge CLK) if (run) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic at_neg(input int k);
      goto(k);
      @(negedge CLK);
   endtask

   task automatic push_ref(input int id, input int c);
      sb_item_t it;
      it.id = id; it.kind = K_REF; it.cyc = c; it.len = 2;
      it.ras = 4'b0000; it.maddr = '0; it.memw = 1'b1; it.cas = 2'b00;
      sb_q.push_back(it);
   endtask

   task automatic start_acc(input int id, input logic [1:0] bank, input logic [9:0] row,
                            input logic [9:0] col, input logic rw, input logic uds,
                            input logic lds, input int exp_cyc, input int exp_len,
                            input logic [3:0] exp_ras);
      sb_item_t it;
      it.id = id; it.kind = K_ACC; it.cyc = exp_cyc; it.len = exp_len;
      it.ras = exp_ras; it.maddr = col; it.memw = rw; it.cas = 2'b11;
      sb_q.push_back(it);
      BANK = bank; ROW = row; COL = col; RWn = rw; UDSn = uds; LDSn = lds;
      SEL = 1'b1; ASn = 1'b0;
   endtask

   task automatic end_acc(input string name);
      ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
      #1;
      chk(name, DTACKn, 1);
   endtask

   task automatic pop_cmp(input int kind, input int c, input int len, input logic [3:0] ras,
                          input logic [9:0] ma, input logic mw, input logic [1:0] cas);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_unexpected: got event kind %0d at edge %0d, required none", kind, c);
         return;
      end
      it = sb_q.pop_front();
      chk($sformatf("ev%0d_kind", it.id), kind, it.kind);
      chk($sformatf("ev%0d_cycle", it.id), c, it.cyc);
      chk($sformatf("ev%0d_len", it.id), len, it.len);
      chk($sformatf("ev%0d_ras", it.id), ras, it.ras);
      chk($sformatf("ev%0d_memw", it.id), mw, it.memw);
      chk($sformatf("ev%0d_cas", it.id), cas, it.cas);
      if (kind == K_ACC) chk($sformatf("ev%0d_maddr", it.id), ma, it.maddr);
   endtask

   // Monitor: an access is a run of DTACKn low, a refresh a run of all RASn low.
   logic       acc_on = 1'b0;
   int         acc_cyc, acc_len;
   logic [3:0] acc_ras;
   logic [9:0] acc_maddr;
   logic       acc_memw;
   logic [1:0] acc_cas;
   logic       ref_on = 1'b0;
   int         ref_cyc, ref_len;
   logic       ref_memw;
   logic [1:0] ref_cas;

   always @(negedge CLK) begin
      if (DTACKn === 1'b0 && !acc_on) begin
         acc_on = 1'b1; acc_cyc = cyc; acc_len = 1; acc_ras = RASn;
         acc_maddr = MADDR; acc_memw = MEMWn; acc_cas = {UCASn, LCASn};
      end else if (DTACKn === 1'b0) begin
         acc_len++;
      end else if (acc_on) begin
         acc_on = 1'b0;
         pop_cmp(K_ACC, acc_cyc, acc_len, acc_ras, acc_maddr, acc_memw, acc_cas);
      end
      if (RASn === 4'b0000 && !ref_on) begin
         ref_on = 1'b1; ref_cyc = cyc; ref_len = 1; ref_memw = MEMWn; ref_cas = {UCASn, LCASn};
      end else if (RASn === 4'b0000) begin
         ref_len++;
      end else if (ref_on) begin
         ref_on = 1'b0;
         pop_cmp(K_REF, ref_cyc, ref_len, 4'b0000, '0, ref_memw, ref_cas);
      end
   end

   initial begin
      RESETn = 1'b1; ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
      SEL = 1'b0; BANK = '0; ROW = '0; COL = '0;
      #3 RESETn = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_rasn", RASn, 4'hF);
      chk("rst_ucasn", UCASn, 1);
      chk("rst_lcasn", LCASn, 1);
      chk("rst_memwn", MEMWn, 1);
      chk("rst_dtackn", DTACKn, 1);
      chk("rst_maddr", MADDR, 0);
      chk("rst_pend", REF_PEND, 0);
      RESETn = 1'b1;
      run    = 1'b1;

      // Idle refresh: tick at edge 108, RCAS 109, RRAS 110-111, done at 112.
      push_ref(1, 110);
      at_neg(107); chk("idle_pend_before_tick", REF_PEND, 0);
      at_neg(108); chk("idle_pend_after_tick", REF_PEND, 1);
      at_neg(112); chk("idle_pend_after_ref", REF_PEND, 0);

      // Read, bank 2.
      goto(113);
      start_acc(2, 2'd2, 10'h155, 10'h0AA, 1'b1, 1'b0, 1'b0, 115, 2, 4'b1011);
      at_neg(114); chk("rd_row_maddr", MADDR, 10'h155); chk("rd_row_rasn", RASn, 4'b1011);
      at_neg(116); chk("rd_ucasn", UCASn, 0); chk("rd_lcasn", LCASn, 0);
      goto(117); end_acc("rd_dtack_release");
      at_neg(118); chk("rd_pre_rasn", RASn, 4'hF); chk("rd_pre_ucasn", UCASn, 1);
      chk("rd_pre_memwn", MEMWn, 1);

      // Byte write with a late lower strobe, bank 1.
      goto(119);
      start_acc(3, 2'd1, 10'h3C3, 10'h111, 1'b0, 1'b1, 1'b1, 121, 2, 4'b1101);
      goto(121); LDSn = 1'b0;
      at_neg(121); chk("wr_lcasn_early", LCASn, 1); chk("wr_memwn", MEMWn, 0);
      at_neg(122); chk("wr_lcasn", LCASn, 0); chk("wr_ucasn", UCASn, 1);
      chk("wr_memwn_hold", MEMWn, 0);
      goto(123); end_acc("wr_dtack_release");

      // Unselected strobe: no cycle, MADDR tracks ROW.
      goto(125); SEL = 1'b0; ASn = 1'b0; ROW = 10'h077;
      for (int k = 126; k <= 128; k++) begin
         at_neg(k);
         chk("nosel_dtackn", DTACKn, 1);
         chk("nosel_rasn", RASn, 4'hF);
         chk("nosel_maddr", MADDR, 10'h077);
      end
      goto(129); ASn = 1'b1; SEL = 1'b1;

      // Long access spans ticks 216/324/432/540/648: backlog saturates at 4.
      goto(130);
      start_acc(4, 2'd0, 10'h2AA, 10'h3FF, 1'b1, 1'b0, 1'b0, 132, 523, 4'b1110);
      at_neg(539); chk("bl_pend_3", REF_PEND, 3);
      at_neg(541); chk("bl_pend_4", REF_PEND, 4);
      at_neg(649); chk("bl_pend_sat", REF_PEND, 4);
      goto(655); end_acc("bl_dtack_release");

      // Access against a full backlog: refresh first, DTACKn 7 edges after ASn.
      goto(657);
      push_ref(5, 659);
      start_acc(6, 2'd2, 10'h155, 10'h2A5, 1'b1, 1'b0, 1'b0, 664, 2, 4'b1011);
      at_neg(661); chk("bl_pend_after_ref", REF_PEND, 3);
      goto(666); end_acc("bl2_dtack_release");
      push_ref(7, 670); push_ref(8, 675); push_ref(9, 680);
      at_neg(683); chk("bl_drained", REF_PEND, 0);

      // Tick at edge 972 coincides with a refresh completion.
      goto(685);
      start_acc(10, 2'd3, 10'h001, 10'h200, 1'b1, 1'b0, 1'b1, 687, 279, 4'b0111);
      at_neg(865); chk("sim_pend_2", REF_PEND, 2);
      goto(966); end_acc("sim_dtack_release");
      push_ref(11, 970); push_ref(12, 975); push_ref(13, 980);
      at_neg(971); chk("sim_pend_pre", REF_PEND, 2);
      at_neg(972); chk("sim_pend_tick_done", REF_PEND, 2);
      at_neg(977); chk("sim_pend_1", REF_PEND, 1);
      at_neg(982); chk("sim_pend_0", REF_PEND, 0);

      // Asynchronous reset in the middle of a COL cycle with one refresh pending.
      goto(984);
      start_acc(14, 2'd2, 10'h0F0, 10'h00F, 1'b1, 1'b0, 1'b0, 986, 99, 4'b1011);
      at_neg(987); chk("rst_col_ucasn", UCASn, 0);
      at_neg(1084); chk("rst_pend_before", REF_PEND, 1);
      goto(1085); #1 RESETn = 1'b0;
      #1;
      chk("arst_rasn", RASn, 4'hF);
      chk("arst_ucasn", UCASn, 1);
      chk("arst_lcasn", LCASn, 1);
      chk("arst_dtackn", DTACKn, 1);
      chk("arst_memwn", MEMWn, 1);
      chk("arst_maddr", MADDR, 0);
      chk("arst_pend", REF_PEND, 0);
      ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
      goto(1086); #1 RESETn = 1'b1;
      at_neg(1087); chk("post_rst_pend", REF_PEND, 0); chk("post_rst_rasn", RASn, 4'hF);

      // Fresh access proves IDLE; next tick 108 edges after release proves counter cleared.
      goto(1088);
      start_acc(15, 2'd1, 10'h100, 10'h0C3, 1'b1, 1'b0, 1'b0, 1090, 2, 4'b1101);
      goto(1092); end_acc("post_rst_dtack_release");
      goto(1094); push_ref(16, 1196);
      at_neg(1193); chk("post_rst_pend_before_tick", REF_PEND, 0);
      at_neg(1194); chk("post_rst_pend_tick", REF_PEND, 1);
      at_neg(1198); chk("post_rst_pend_done", REF_PEND, 0);

      goto(1202);
      chk("sb_drained", sb_q.size(), 0);
      chk("mon_idle", {30'd0, acc_on, ref_on}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
